// File: rtl/float16_pkg.sv
// Shared half-precision definitions for the float_arith divider/multiplier family.
// Zero and clamp constants are common to all operators in the group.
package float16_pkg;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [14:0] FP16_MAX_MAG = 15'h7FFF;
  localparam logic [15:0] FP16_ZERO    = 16'h0000;

  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
endpackage

// File: rtl/fp16_man_div.sv
// Radix-2 restoring divider for 11-bit normalised mantissas.
// Produces floor(dividend * 2^12 / divisor) over 13 iterations, then a one-cycle done pulse.
module fp16_man_div
  import float16_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [MAN_W:0]   dividend,
  input  logic [MAN_W:0]   divisor,
  output logic             done,
  output logic [MAN_W+2:0] quotient
);
  localparam logic [3:0] LAST_ITER = 4'(MAN_W + 2);

  logic [MAN_W+1:0] rem_reg;
  logic [MAN_W:0]   div_reg;
  logic [MAN_W+2:0] q_reg;
  logic [3:0]       cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [MAN_W+2:0] t;

  // One extra bit above the remainder acts as the sign of the trial subtraction.
  assign t = {1'b0, rem_reg} - {2'b00, div_reg};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_reg  <= '0;
      div_reg  <= '0;
      q_reg    <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        rem_reg  <= {1'b0, dividend};
        div_reg  <= divisor;
        q_reg    <= '0;
        cnt_reg  <= LAST_ITER;
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        q_reg   <= {q_reg[MAN_W+1:0], ~t[MAN_W+2]};
        rem_reg <= (t[MAN_W+2] ? rem_reg : t[MAN_W+1:0]) << 1;
        if (cnt_reg == 4'd0) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg - 4'd1;
        end
      end
    end
  end

  assign done     = done_reg;
  assign quotient = q_reg;
endmodule

// File: rtl/float_div_16.sv
// Sequential half-precision divider x = a / b with valid/ready on both sides.
// Fixed 15-cycle accept-to-result latency; special cases still run the full iteration.
module float_div_16
  import float16_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] data_1_i,
  input  logic [15:0] data_2_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] data_div_o
);
  fp16_t a_in, b_in, result;
  assign a_in = data_1_i;
  assign b_in = data_2_i;

  state_t            state_reg, state_next;
  logic              sgn_reg, za_reg, zb_reg;
  logic signed [7:0] exp_reg, exp_norm, exp_fin;
  logic [15:0]       data_div_reg;
  logic              start, load_result, div_done, guard;
  logic [MAN_W+2:0]  quot;
  logic [MAN_W-1:0]  man_pre, man_fin;
  logic [MAN_W:0]    man_sum;

  fp16_man_div u_man_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .dividend ({1'b1, a_in.man}),
    .divisor  ({1'b1, b_in.man}),
    .done     (div_done),
    .quotient (quot)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      sgn_reg      <= 1'b0;
      za_reg       <= 1'b0;
      zb_reg       <= 1'b0;
      exp_reg      <= '0;
      data_div_reg <= FP16_ZERO;
    end else begin
      state_reg <= state_next;
      if (start) begin
        sgn_reg <= a_in.sgn ^ b_in.sgn;
        // Zero exponent covers both true zero and flushed denormals.
        za_reg  <= (a_in.exp == '0);
        zb_reg  <= (b_in.exp == '0);
        exp_reg <= 8'(a_in.exp) - 8'(b_in.exp) + 8'(BIAS);
      end
      if (load_result) data_div_reg <= result;
    end
  end

  always_comb begin
    state_next  = state_reg;
    start       = 1'b0;
    load_result = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          start      = 1'b1;
          state_next = DIV;
        end
      end
      DIV:  if (div_done) state_next = NORM;
      NORM: begin
        load_result = 1'b1;
        state_next  = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Normalise the quotient, round half-up on the guard bit, then apply zero/clamp rules.
  always_comb begin
    if (quot[MAN_W+2]) begin
      man_pre  = quot[MAN_W+1:2];
      guard    = quot[1];
      exp_norm = exp_reg;
    end else begin
      man_pre  = quot[MAN_W:1];
      guard    = quot[0];
      exp_norm = exp_reg - 8'sd1;
    end
    man_sum = {1'b0, man_pre} + {{MAN_W{1'b0}}, guard};
    if (man_sum[MAN_W]) begin
      man_fin = '0;
      exp_fin = exp_norm + 8'sd1;
    end else begin
      man_fin = man_sum[MAN_W-1:0];
      exp_fin = exp_norm;
    end

    result = FP16_ZERO;
    if (zb_reg)                result = {sgn_reg, FP16_MAX_MAG};
    else if (za_reg)           result = FP16_ZERO;
    else if (exp_fin <= 8'sd0) result = FP16_ZERO;
    else if (exp_fin > 8'sd31) result = {sgn_reg, FP16_MAX_MAG};
    else                       result = {sgn_reg, exp_fin[EXP_W-1:0], man_fin};
  end

  assign data_div_o = data_div_reg;
endmodule

// File: doc/float_div_16.md
Name: float_div_16

Overview:
- Sequential half-precision divider: x = a / b on 16-bit floats (1 sign, 5 exp, 10 mantissa, bias 15), radix-2 restoring mantissa division.
- Inverse operator to the pipelined mult_16 in the float_arith group; same number format, zero/overflow and rounding rules, so div results recombine with mult results.
- Valid/ready on both sides; one operation in flight; fixed latency.

Parameters:
- EXP_W, 5, exponent width
- MAN_W, 10, stored mantissa width
- BIAS, 15, exponent bias

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- data_1_i  in  16  dividend a
- data_2_i  in  16  divisor b
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- data_div_o  out  16  quotient x

Behaviour:
- Format rules:
  - operand is zero iff bits[14:0]==0, either sign; exp==0 with nonzero mantissa is also treated as zero (no denormals).
  - exp 31 is an ordinary normal value: no inf/NaN.
- Reset values: state IDLE, in_ready=1, out_valid=0, data_div_o=16'h0000; iteration counter 0.
- States:
  - IDLE: in_ready=1.
    - On in_valid: latch a and b.
    - Latch s = a.sgn^b.sgn.
    - Latch e = ea - eb + BIAS as signed 8-bit.
    - Latch zero flags za, zb.
    - Load remainder = {1,ma}, divisor = {1,mb}, counter = 12.
    - Go to DIV.
  - DIV, 13 cycles:
    - Each cycle compute t = rem - div.
    - q = {q[11:0], ~t[msb]}.
    - rem = (t>=0 ? t : rem) << 1.
    - Counter decrements; after counter==0, go to NORM.
    - q[12:0] = floor(Ma·2^12 / Mb), in range [2^11, 2^13).
  - NORM, 1 cycle:
    - If q[12]: man = q[11:2], guard = q[1]; else man = q[10:1], guard = q[0], e = e-1.
    - Round half-up on guard: man+guard; on carry out of 10 bits, man=0 and e=e+1.
    - Special cases, in priority order:
      1. zb: x = {s, 5'h1F, 10'h3FF}.
      2. za: x = 16'h0000.
      3. e<=0: x = 16'h0000 (sign cleared).
      4. e>31: x = {s, 5'h1F, 10'h3FF}.
      5. otherwise x = {s, e[4:0], man}.
    - Register data_div_o; go to DONE.
  - DONE: out_valid=1 and data_div_o held stable.
    - On out_ready: out_valid=0, go to IDLE.
    - in_valid is ignored; in_ready=0 in DIV/NORM/DONE.
- Timing:
  - Accept at edge T; out_valid high after edge T+15, fixed regardless of operand values, specials included.
  - Minimum accept-to-accept interval is 16 cycles with out_ready tied high.
  - New operands cannot be accepted in the same cycle as result handshake; next accept is from IDLE.
- Width rules:
  - Remainder register is 12 bits plus sign for t.
  - Exponent arithmetic is signed, wide enough for range -30..+46 before clamping.
- Reset mid-operation: reset_n low at any edge returns to the reset values on that edge. The in-flight result is discarded with no out_valid pulse.
- Handshake rules:
  - out_valid, once high, never drops without out_ready.
  - data_div_o never changes while out_valid=1 and out_ready=0.

Decomposition:
- Package float16_pkg:
  - EXP_W, MAN_W, BIAS.
  - FP16_MAX_MAG = 15'h7FFF and FP16_ZERO.
  - typedef fp16_t struct packed {sgn, exp, man}.
  - State enum {IDLE, DIV, NORM, DONE}.
- One natural sub-module, fp16_man_div: restoring iterative 11-bit mantissa divider with start/done and 13-bit quotient.
- Exponent, special-case and rounding logic stays in float_div_16.

Test Plan:
- 0x3C00 / 0x3C00 (1.0/1.0) -> 0x3C00 at exactly 15 cycles after accept; 0x4600 / 0x4000 (6/2) -> 0x4200.
- 0x3C00 / 0x4200 (1/3) -> 0x3555 (normalize path, guard 0); 0xBC00 / 0x4000 (-1/2) -> 0xB800.
- 0xC000 / 0x0000 (divide by zero) -> 0xFFFF; 0x0000 / 0x4000 -> 0x0000; 0x8000 / 0x4000 -> 0x0000.
- Overflow 0x7800 / 0x0400 -> 0x7FFF; underflow 0x0400 / 0x7800 -> 0x0000.
- Backpressure: out_ready low 10 cycles after out_valid -> data_div_o and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready high -> in_ready=1 next cycle.
- reset_n low during DIV (cycle 6) -> no out_valid; next op 0x4000 / 0x3C00 -> 0x4000.
- Random regression against a real-arithmetic model using the same zero, clamp and guard-round rules.
